// File: rtl/volume.sv
// -----------------------------------------------------------------------------
// volume -- output gain stage of the synthesis chain
//
// Scales each 24-bit signed sample by an 8-bit unsigned gain (128 = unity).
// The applied gain moves toward the requested target one LSB at a time, with
// one step every RAMP_DIV accepted samples. Stepping this way avoids zipper
// noise and clicks when the gain or mute changes. Results are saturated to
// 24 bits and registered, so each sample appears one cycle after it is
// accepted.
//
// Handshake (valid/ready):
//   A sample transfers on a rising edge where in_valid & out_ready. in_ready is
//   a combinational copy of out_ready, so nothing is ever buffered here: while
//   out_ready is low, upstream must hold its sample. out_valid is a one-cycle
//   pulse per accepted sample. Downstream must take it in that cycle, and it
//   does so because it was ready when the sample was accepted.
//
// Parameters:
//   RAMP_DIV     accepted samples per one-LSB gain step (1..65535)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   in_data      signed input sample
//   in_valid     in_data valid this cycle
//   in_ready     combinational copy of out_ready
//   target_gain  unsigned gain target (128 = unity)
//   mute         forces the effective target to 0
//   out_data     signed scaled, saturated sample (0 when not valid)
//   out_valid    one-cycle pulse per accepted sample
//   out_ready    downstream can take a sample
//   gain         currently applied gain (register value)
//   clip         high with out_valid when the sample saturated
//   dbg_state    ramp FSM state (0 STEADY, 1 UP, 2 DOWN)
//   dbg_cnt      ramp step counter
// -----------------------------------------------------------------------------
module volume #(
  parameter int unsigned RAMP_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  target_gain,
  input  logic        mute,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  gain,
  output logic        clip,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_cnt
);

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2
  } state_e;

  localparam logic [15:0]        CNT_LAST = 16'(RAMP_DIV - 1);
  localparam logic signed [32:0] SAT_MAX  = 33'sd8388607;
  localparam logic signed [32:0] SAT_MIN  = -33'sd8388608;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  gain_q, gain_d;
  logic [23:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        clip_q, clip_d;

  logic        accept;
  logic [7:0]  eff;

  // Datapath signals
  logic signed [32:0] din_ext;
  logic signed [32:0] gain_ext;
  logic signed [32:0] prod;
  logic signed [32:0] shifted;
  logic [23:0]        sat_data;
  logic               sat_hit;

  assign accept   = in_valid & out_ready;
  assign in_ready = out_ready;
  assign eff      = mute ? 8'd0 : target_gain;

  // ---------------------------------------------------------------------------
  // Scaling. The operands are widened explicitly to the product width. The
  // largest magnitude, 2^23 * 255, fits in 33 signed bits. The arithmetic
  // shift floors toward minus infinity, so -3 * 64 / 128 gives -2.
  // The multiply always uses gain_q: any gain step taken on this same accept
  // only affects later samples.
  // ---------------------------------------------------------------------------
  always_comb begin
    din_ext  = {{9{in_data[23]}}, in_data};
    gain_ext = {25'd0, gain_q};
    prod     = din_ext * gain_ext;
    shifted  = prod >>> 7;
    sat_hit  = 1'b0;
    sat_data = shifted[23:0];
    if (shifted > SAT_MAX) begin
      sat_data = 24'h7FFFFF;
      sat_hit  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_data = 24'h800000;
      sat_hit  = 1'b1;
    end
  end

  // Output register inputs. These are zero on any cycle without an accept.
  always_comb begin
    out_data_d  = 24'd0;
    out_valid_d = 1'b0;
    clip_d      = 1'b0;
    if (accept) begin
      out_data_d  = sat_data;
      out_valid_d = 1'b1;
      clip_d      = sat_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp FSM. It only moves on accept cycles. Direction and equality checks
  // come before the step, so a target change that lands on a step boundary
  // never overshoots. Gain stays inside 0..255 for two reasons: UP only steps
  // while eff > gain (so gain < 255), and DOWN only steps while eff < gain
  // (so gain > 0).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    if (accept) begin
      unique case (state_q)
        STEADY: begin
          if (eff > gain_q) begin
            state_d = UP;
            cnt_d   = 16'd0;
          end else if (eff < gain_q) begin
            state_d = DOWN;
            cnt_d   = 16'd0;
          end
        end
        UP: begin
          if (eff < gain_q) begin
            state_d = DOWN;
            cnt_d   = 16'd0;
          end else if (eff == gain_q) begin
            state_d = STEADY;
            cnt_d   = 16'd0;
          end else if (cnt_q == CNT_LAST) begin
            gain_d = gain_q + 8'd1;
            cnt_d  = 16'd0;
            if (gain_q + 8'd1 == eff) state_d = STEADY;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        DOWN: begin
          if (eff > gain_q) begin
            state_d = UP;
            cnt_d   = 16'd0;
          end else if (eff == gain_q) begin
            state_d = STEADY;
            cnt_d   = 16'd0;
          end else if (cnt_q == CNT_LAST) begin
            gain_d = gain_q - 8'd1;
            cnt_d  = 16'd0;
            if (gain_q - 8'd1 == eff) state_d = STEADY;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = STEADY;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STEADY;
      cnt_q       <= 16'd0;
      gain_q      <= 8'd0;
      out_data_q  <= 24'd0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gain_q      <= gain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      clip_q      <= clip_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign clip      = clip_q;
  assign gain      = gain_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_volume.sv
// -----------------------------------------------------------------------------
// tb_volume -- self-checking bench for volume
//
// Two instances are used: u_div1 (RAMP_DIV=1) and u_div4 (RAMP_DIV=4). They
// share all inputs except in_valid, so the idle instance holds its state.
// The driver pushes the hand-computed expected {clip, data} for each sample
// into the instance's queue. A monitor on the falling edge pops that entry
// whenever out_valid is seen and compares it against the output.
// -----------------------------------------------------------------------------
module tb_volume;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [23:0] in_data;
  logic        in_valid1, in_valid4;
  logic [7:0]  target_gain;
  logic        mute;
  logic        out_ready;

  logic        in_ready1, out_valid1, clip1;
  logic [23:0] out_data1;
  logic [7:0]  gain1;
  logic [1:0]  st1;
  logic [15:0] cnt1;

  logic        in_ready4, out_valid4, clip4;
  logic [23:0] out_data4;
  logic [7:0]  gain4;
  logic [1:0]  st4;
  logic [15:0] cnt4;

  volume #(.RAMP_DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
    .in_ready(in_ready1), .target_gain(target_gain), .mute(mute),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .gain(gain1), .clip(clip1), .dbg_state(st1), .dbg_cnt(cnt1)
  );

  volume #(.RAMP_DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid4),
    .in_ready(in_ready4), .target_gain(target_gain), .mute(mute),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .gain(gain4), .clip(clip4), .dbg_state(st4), .dbg_cnt(cnt4)
  );

  localparam int ST_STEADY = 0;
  localparam int ST_UP     = 1;
  localparam int ST_DOWN   = 2;

  // ----------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  logic [24:0] exp_q1[$];
  logic [24:0] exp_q4[$];
  logic [24:0] e1, e4;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid1) begin
        if (exp_q1.size() == 0) chk("div1 unexpected out_valid", 1, 0);
        else begin
          e1 = exp_q1.pop_front();
          chk("div1 out_data", int'($signed(out_data1)), int'($signed(e1[23:0])));
          chk("div1 clip", int'(clip1), int'(e1[24]));
        end
      end else begin
        chk("div1 idle out_data", int'(out_data1), 0);
        chk("div1 idle clip", int'(clip1), 0);
      end
      if (out_valid4) begin
        if (exp_q4.size() == 0) chk("div4 unexpected out_valid", 1, 0);
        else begin
          e4 = exp_q4.pop_front();
          chk("div4 out_data", int'($signed(out_data4)), int'($signed(e4[23:0])));
          chk("div4 clip", int'(clip4), int'(e4[24]));
        end
      end else begin
        chk("div4 idle out_data", int'(out_data4), 0);
        chk("div4 idle clip", int'(clip4), 0);
      end
    end
  end

  // -------------------------------------------------------------------- driver
  // Offer one sample to the chosen instance (out_ready must be high). After
  // the accepting edge, check the instance's gain and ramp counter.
  task automatic send(input int sel, input int d, input int exp_d, input bit exp_c,
                      input int exp_g, input int exp_cnt);
    logic [24:0] ent;
    ent     = {exp_c, exp_d[23:0]};
    in_data = d[23:0];
    if (sel == 1) begin
      in_valid1 = 1'b1;
      exp_q1.push_back(ent);
    end else begin
      in_valid4 = 1'b1;
      exp_q4.push_back(ent);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    if (sel == 1) begin
      chk("div1 gain", int'(gain1), exp_g);
      chk("div1 cnt", int'(cnt1), exp_cnt);
    end else begin
      chk("div4 gain", int'(gain4), exp_g);
      chk("div4 cnt", int'(cnt4), exp_cnt);
    end
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    int gb;
    reset       = 1'b1;
    in_data     = 24'd0;
    in_valid1   = 1'b0;
    in_valid4   = 1'b0;
    target_gain = 8'd0;
    mute        = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state of both instances
    chk("rst div1 out_data", int'(out_data1), 0);
    chk("rst div1 out_valid", int'(out_valid1), 0);
    chk("rst div1 clip", int'(clip1), 0);
    chk("rst div1 gain", int'(gain1), 0);
    chk("rst div1 state", int'(st1), ST_STEADY);
    chk("rst div1 cnt", int'(cnt1), 0);
    chk("rst div1 in_ready", int'(in_ready1), 1);
    chk("rst div4 out_valid", int'(out_valid4), 0);
    chk("rst div4 gain", int'(gain4), 0);
    chk("rst div4 state", int'(st4), ST_STEADY);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Startup ramp 0 -> 128 over 129 samples of 1000. Each output uses the
    // gain from before that accept: 0 for the first two samples, then k-2.
    target_gain = 8'd128;
    for (int k = 1; k <= 129; k++) begin
      gb = (k < 2) ? 0 : k - 2;
      send(1, 1000, (1000 * gb) / 128, 1'b0, k - 1, 0);
    end
    chk("startup state STEADY", int'(st1), ST_STEADY);
    send(1, 1000, 1000, 1'b0, 128, 0);

    // Ramp to 255: takes 1 + 127 samples
    target_gain = 8'd255;
    for (int j = 1; j <= 128; j++) send(1, 0, 0, 1'b0, 128 + j - 1, 0);
    chk("at 255 state STEADY", int'(st1), ST_STEADY);

    // Saturation and its edges at gain 255
    send(1, 8388607, 8388607, 1'b1, 255, 0);
    send(1, -8388608, -8388608, 1'b1, 255, 0);
    send(1, 4000000, 7968750, 1'b0, 255, 0);
    send(1, 4210752, 8388607, 1'b0, 255, 0);   // 8388607.5 floors to max, no clip
    send(1, 4210753, 8388607, 1'b1, 255, 0);
    send(1, -4210752, -8388608, 1'b0, 255, 0); // -8388607.5 floors to min, no clip

    // Down to 64: takes 1 + 191 samples
    target_gain = 8'd64;
    for (int j = 1; j <= 192; j++) send(1, 0, 0, 1'b0, 255 - (j - 1), 0);
    chk("at 64 state STEADY", int'(st1), ST_STEADY);

    // Floor rounding at gain 64
    send(1, -3, -2, 1'b0, 64, 0);
    send(1, 3, 1, 1'b0, 64, 0);

    // Reset mid-ramp at gain 70, with in_valid held high
    target_gain = 8'd128;
    for (int j = 1; j <= 7; j++) send(1, 0, 0, 1'b0, 64 + j - 1, 0);
    chk("pre-reset state UP", int'(st1), ST_UP);
    reset     = 1'b1;
    in_valid1 = 1'b1;
    in_data   = 24'd500;
    @(posedge clk);
    @(negedge clk);
    chk("mid-ramp reset gain", int'(gain1), 0);
    chk("mid-ramp reset out_valid", int'(out_valid1), 0);
    chk("mid-ramp reset out_data", int'(out_data1), 0);
    chk("mid-ramp reset clip", int'(clip1), 0);
    chk("mid-ramp reset state", int'(st1), ST_STEADY);
    reset     = 1'b0;
    in_valid1 = 1'b0;

    // RAMP_DIV=4: rise toward 100. After accept n, gain = (n-1)/4 and
    // cnt = (n-1)%4. Backpressure is applied before accept 104.
    target_gain = 8'd100;
    for (int n = 1; n <= 201; n++) begin
      if (n == 104) begin
        out_ready = 1'b0;
        in_valid4 = 1'b1;
        in_data   = 24'd1000;
        for (int c = 0; c < 10; c++) begin
          @(posedge clk);
          @(negedge clk);
          chk("bp in_ready", int'(in_ready4), 0);
          chk("bp out_valid", int'(out_valid4), 0);
          chk("bp gain hold", int'(gain4), 25);
          chk("bp cnt hold", int'(cnt4), 2);
        end
        in_valid4 = 1'b0;
        out_ready = 1'b1;
      end
      gb = (n < 2) ? 0 : (n - 2) / 4;
      send(4, 1000, (1000 * gb) / 128, 1'b0, (n - 1) / 4, (n - 1) % 4);
    end
    chk("div4 rising at 50 state UP", int'(st4), ST_UP);

    // Mute: the next accept turns the ramp to DOWN. After accept k,
    // gain = 50 - (k-1)/4, reaching 0 at k = 201.
    mute = 1'b1;
    for (int k = 1; k <= 201; k++) begin
      gb = (k < 2) ? 50 : 50 - (k - 2) / 4;
      send(4, 1000, (1000 * gb) / 128, 1'b0, 50 - (k - 1) / 4, (k - 1) % 4);
      if (k == 1) chk("mute turns DOWN", int'(st4), ST_DOWN);
    end
    chk("muted state STEADY", int'(st4), ST_STEADY);
    send(4, 1000, 0, 1'b0, 0, 0);

    // Drain and report
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("queues drained", exp_q1.size() + exp_q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
